stream_demux_n: RTL and testbench

Registered, parametrised 1-to-N stream demultiplexer with valid/ready handshaking: the successor to the fixed 1-to-4 combinational demux. An input word is steered by a select field into one of N single-entry output holding registers, or broadcast to all of them, and is held there until that channel's consumer accepts it. It sits between a single producer and N independent consumers that can stall independently.

---
 rtl/stream_demux_n.sv | 50 +++++
 tb/tb_stream_demux_n.sv | 133 +++++++++++++
 2 files changed

// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-N valid/ready stream demux with per-channel holding slots and broadcast.
// Ports: clk/rst_n (async active-low), en gates intake only; in_valid/in_ready/in_data/in_sel/in_bcast
// form the producer side; out_valid/out_ready/out_data (channel i at [i*WIDTH +: WIDTH]) the N consumer
// sides; drop_cnt counts words discarded for an illegal select, saturating at 255.
module stream_demux_n #(
  parameter int WIDTH = 8,
  parameter int N = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_bcast,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [7:0]         drop_cnt
);
  logic [N-1:0] v, free, load;
  logic [WIDTH-1:0] data_q [N];
  logic illegal, acc, drop;
  // a slot is free when empty or being drained on this same edge
  assign free = ~v | out_ready;
  assign illegal = 32'(in_sel) >= N;
  assign in_ready = !en ? 1'b0 : in_bcast ? &free : illegal ? 1'b1 : free[in_sel];
  assign acc = in_valid & in_ready;
  assign drop = acc & !in_bcast & illegal;
  assign out_valid = v;
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign load[i] = acc & (in_bcast | (!illegal && in_sel == SEL_W'(i)));
    assign out_data[i*WIDTH +: WIDTH] = data_q[i];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v[i] <= 1'b0;
        data_q[i] <= '0;
      end else begin
        v[i] <= load[i] | (v[i] & !out_ready[i]);
        if (load[i]) data_q[i] <= in_data;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
endmodule

// File: tb/tb_stream_demux_n.sv
// tb_stream_demux_n: table-driven, scoreboarded check of stream_demux_n (N=4 main, N=3 for illegal selects).
module tb_stream_demux_n;
  logic clk = 0, rst_n = 0;
  logic en, in_valid, in_bcast, in_ready;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid, out_ready;
  logic [31:0] out_data;
  logic [7:0] drop_cnt;
  logic en3, in_valid3, in_bcast3, in_ready3;
  logic [7:0] in_data3, drop_cnt3;
  logic [1:0] in_sel3;
  logic [2:0] out_valid3, out_ready3;
  logic [23:0] out_data3;
  int total = 0, bad = 0;
  logic [7:0] q [4][$];
  logic [7:0] last [4];
  typedef struct {
    logic en, valid, bcast;
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] ordy;
    logic exp_rdy;
  } vec_t;
  vec_t tbl [$];
  always #5 clk = ~clk;
  stream_demux_n #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .drop_cnt(drop_cnt));
  stream_demux_n #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_sel(in_sel3), .in_bcast(in_bcast3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .drop_cnt(drop_cnt3));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic step(input vec_t v);
    logic [7:0] e;
    en = v.en; in_valid = v.valid; in_bcast = v.bcast; in_sel = v.sel;
    in_data = v.data; out_ready = v.ordy;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, v.exp_rdy});
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_valid[%0d]", i), {31'd0, out_valid[i]}, {31'd0, q[i].size() != 0});
      if (v.ordy[i] && q[i].size() != 0) begin
        e = q[i].pop_front();
        chk($sformatf("out_data[%0d] drained", i), {24'd0, out_data[i*8 +: 8]}, {24'd0, e});
      end else begin
        chk($sformatf("out_data[%0d] held", i), {24'd0, out_data[i*8 +: 8]}, {24'd0, last[i]});
      end
    end
    if (v.valid && v.exp_rdy)
      for (int i = 0; i < 4; i++)
        if (v.bcast || v.sel == 2'(i)) begin
          q[i].push_back(v.data);
          last[i] = v.data;
        end
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    en = 1; in_valid = 0; in_bcast = 0; in_sel = 0; in_data = 0; out_ready = 0;
    en3 = 1; in_valid3 = 0; in_bcast3 = 0; in_sel3 = 2'd3; in_data3 = 8'h5C; out_ready3 = 0;
    for (int i = 0; i < 4; i++) last[i] = 0;
    // {en, valid, bcast, sel, data, out_ready, expected in_ready}
    tbl.push_back('{1, 1, 0, 2'd0, 8'hA0, 4'hF, 1});
    tbl.push_back('{1, 1, 0, 2'd1, 8'hA1, 4'hF, 1});
    tbl.push_back('{1, 1, 0, 2'd2, 8'hA2, 4'hF, 1});
    tbl.push_back('{1, 1, 0, 2'd3, 8'hA3, 4'hF, 1});
    tbl.push_back('{1, 0, 0, 2'd0, 8'h00, 4'hF, 1});
    tbl.push_back('{1, 1, 0, 2'd2, 8'h55, 4'hB, 1});
    tbl.push_back('{1, 1, 0, 2'd2, 8'h66, 4'hB, 0});
    tbl.push_back('{1, 1, 0, 2'd2, 8'h66, 4'hB, 0});
    tbl.push_back('{1, 1, 0, 2'd1, 8'h77, 4'hB, 1});
    tbl.push_back('{1, 1, 0, 2'd2, 8'h66, 4'hF, 1});
    tbl.push_back('{1, 0, 0, 2'd0, 8'h00, 4'hF, 1});
    tbl.push_back('{1, 1, 0, 2'd2, 8'h88, 4'hB, 1});
    tbl.push_back('{1, 1, 1, 2'd0, 8'hC3, 4'hB, 0});
    tbl.push_back('{1, 1, 1, 2'd1, 8'hC3, 4'hB, 0});
    tbl.push_back('{1, 1, 1, 2'd0, 8'hC3, 4'hF, 1});
    tbl.push_back('{1, 0, 0, 2'd0, 8'h00, 4'h0, 0});
    tbl.push_back('{1, 0, 0, 2'd0, 8'h00, 4'hF, 1});
    tbl.push_back('{1, 0, 0, 2'd0, 8'h00, 4'h0, 1});
    tbl.push_back('{1, 1, 0, 2'd0, 8'h5A, 4'h0, 1});
    tbl.push_back('{0, 1, 0, 2'd0, 8'h99, 4'h1, 0});
    tbl.push_back('{1, 0, 0, 2'd0, 8'h00, 4'h0, 1});
    tbl.push_back('{1, 1, 0, 2'd1, 8'h11, 4'h0, 1});
    tbl.push_back('{1, 1, 0, 2'd2, 8'h22, 4'h0, 1});
    repeat (2) @(negedge clk);
    chk("reset out_valid", {28'd0, out_valid}, 0);
    chk("reset out_data", out_data, 0);
    chk("reset drop_cnt", {24'd0, drop_cnt}, 0);
    chk("reset in_ready", {31'd0, in_ready}, 1);
    rst_n = 1;
    @(negedge clk);
    for (int k = 0; k < tbl.size(); k++) step(tbl[k]);
    chk("pre-reset out_valid", {28'd0, out_valid}, 32'h6);
    chk("pre-reset out_data[2]", {24'd0, out_data[23:16]}, 32'h22);
    in_valid3 = 1;
    for (int i = 0; i < 300; i++) begin
      #1;
      chk("n3 in_ready", {31'd0, in_ready3}, 1);
      chk("n3 out_valid", {29'd0, out_valid3}, 0);
      if (i % 50 == 0) chk("n3 drop_cnt ramp", {24'd0, drop_cnt3}, i > 255 ? 255 : i);
      @(posedge clk);
      @(negedge clk);
    end
    chk("n3 drop_cnt sat", {24'd0, drop_cnt3}, 255);
    in_valid3 = 0;
    #2 rst_n = 0;
    #1;
    chk("async out_valid", {28'd0, out_valid}, 0);
    chk("async out_data", out_data, 0);
    chk("async drop_cnt", {24'd0, drop_cnt}, 0);
    chk("async n3 drop_cnt", {24'd0, drop_cnt3}, 0);
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      last[i] = 0;
    end
    @(negedge clk);
    rst_n = 1;
    step('{1, 1, 0, 2'd3, 8'hEE, 4'h0, 1});
    step('{1, 0, 0, 2'd0, 8'h00, 4'hF, 1});
    step('{1, 0, 0, 2'd0, 8'h00, 4'h0, 1});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
